// File: rtl/ysyx_22041461_alu_pkg.sv
// Shared ALU opcodes, shifter FSM states and operand helpers used by the
// multi-cycle shift units.
package ysyx_22041461_alu_pkg;

   localparam logic [4:0] ALU_SLL   = 5'b00101;
   localparam logic [4:0] ALU_SLLW  = 5'b11001;
   localparam logic [4:0] ALU_SLLIW = 5'b11010;
   localparam logic [4:0] ALU_SRA   = 5'b00111;
   localparam logic [4:0] ALU_SRAW  = 5'b11011;
   localparam logic [4:0] ALU_SRAIW = 5'b11100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } sll_state_e;

   function automatic logic is_w_op(input logic [4:0] op);
      return (op == ALU_SLLW) || (op == ALU_SLLIW);
   endfunction

   // Illegal codes get a zero shift so they finish straight away with a zero result.
   function automatic logic [5:0] shamt_of(input logic [4:0] op, input logic [5:0] amt);
      logic [5:0] sh;
      if (op == ALU_SLL) begin
         sh = amt;
      end else if (is_w_op(op)) begin
         sh = {1'b0, amt[4:0]};
      end else begin
         sh = 6'd0;
      end
      return sh;
   endfunction

   function automatic logic [63:0] format_result(input logic [4:0] op, input logic [63:0] acc);
      logic [63:0] res;
      if (op == ALU_SLL) begin
         res = acc;
      end else if (is_w_op(op)) begin
         res = {{32{acc[31]}}, acc[31:0]};
      end else begin
         res = 64'd0;
      end
      return res;
   endfunction

endpackage

// File: rtl/ysyx_22041461_sll_step.sv
// One iteration of the left shifter: shifts acc by min(cnt, STEP) with zero fill
// and returns the shift count still outstanding.
module ysyx_22041461_sll_step #(
   parameter int unsigned STEP = 8
) (
   input  logic [63:0] acc,
   input  logic [5:0]  cnt,
   output logic [63:0] acc_next,
   output logic [5:0]  cnt_next
);
   localparam logic [5:0] STEP_W = 6'(STEP);

   logic [5:0] d_s;

   // Per-cycle shift distance, capped at STEP.
   always_comb begin
      d_s      = (cnt < STEP_W) ? cnt : STEP_W;
      acc_next = acc << d_s;
      cnt_next = cnt - d_s;
   end

endmodule

// File: rtl/ysyx_22041461_sll_iter.sv
// Iterative SLL/SLLW/SLLIW unit with valid/ready handshakes on both sides.
// Optional build macro YSYX_22041461_SLL_EARLY_OUT_EN finishes as soon as the shifted value is zero.
module ysyx_22041461_sll_iter
   import ysyx_22041461_alu_pkg::*;
#(
   parameter int unsigned STEP = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] src1,
   input  logic [63:0] src2,
   input  logic [4:0]  ctrl_ALU,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] SLL_out
);

   sll_state_e  state_r, state_s;
   logic [63:0] acc_r, acc_s, step_acc_s;
   logic [63:0] sll_out_r, sll_out_s;
   logic [5:0]  cnt_r, cnt_s, step_cnt_s;
   logic [4:0]  op_r, op_s;
   logic        out_valid_r, out_valid_s;
   logic        early_s;

   ysyx_22041461_sll_step #(.STEP(STEP)) u_step (
      .acc      (acc_r),
      .cnt      (cnt_r),
      .acc_next (step_acc_s),
      .cnt_next (step_cnt_s)
   );

   // Zero-value detect that lets SHIFT finish before cnt runs out.
   always_comb begin
      early_s = 1'b0;
`ifdef YSYX_22041461_SLL_EARLY_OUT_EN
      if (is_w_op(op_r)) begin
         early_s = (acc_r[31:0] == 32'd0);
      end else begin
         early_s = (acc_r == 64'd0);
      end
`endif
   end

   // Next-state and datapath decode.
   always_comb begin
      state_s     = state_r;
      acc_s       = acc_r;
      cnt_s       = cnt_r;
      op_s        = op_r;
      out_valid_s = out_valid_r;
      sll_out_s   = sll_out_r;
      case (state_r)
         ST_IDLE: begin
            if (flush) begin
               state_s = ST_IDLE;
            end else if (in_valid) begin
               acc_s   = src1;
               op_s    = ctrl_ALU;
               cnt_s   = shamt_of(ctrl_ALU, src2[5:0]);
               state_s = (cnt_s == 6'd0) ? ST_DONE : ST_SHIFT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (flush) begin
               state_s     = ST_IDLE;
               out_valid_s = 1'b0;
            end else begin
               acc_s = step_acc_s;
               cnt_s = step_cnt_s;
               if ((step_cnt_s == 6'd0) || early_s) begin
                  state_s     = ST_DONE;
                  out_valid_s = 1'b1;
                  sll_out_s   = format_result(op_r, step_acc_s);
               end else begin
                  state_s = ST_SHIFT;
               end
            end
         end
         ST_DONE: begin
            // A zero-count op arrives here straight from IDLE without a result yet.
            if (flush) begin
               state_s     = ST_IDLE;
               out_valid_s = 1'b0;
            end else if (!out_valid_r) begin
               out_valid_s = 1'b1;
               sll_out_s   = format_result(op_r, acc_r);
            end else if (out_ready) begin
               state_s     = ST_IDLE;
               out_valid_s = 1'b0;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s     = ST_IDLE;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         acc_r       <= 64'd0;
         cnt_r       <= 6'd0;
         op_r        <= 5'd0;
         out_valid_r <= 1'b0;
         sll_out_r   <= 64'd0;
      end else begin
         state_r     <= state_s;
         acc_r       <= acc_s;
         cnt_r       <= cnt_s;
         op_r        <= op_s;
         out_valid_r <= out_valid_s;
         sll_out_r   <= sll_out_s;
      end
   end

   assign in_ready  = (state_r == ST_IDLE);
   assign out_valid = out_valid_r;
   assign SLL_out   = sll_out_r;

endmodule

// File: tb/tb_ysyx_22041461_sll_iter.sv
// Scoreboard bench for ysyx_22041461_sll_iter: directed cases plus random ops
// checked against a direct-shift reference model.
module tb_ysyx_22041461_sll_iter;
   import ysyx_22041461_alu_pkg::*;

   localparam int STEP = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] src1 = 64'd0;
   logic [63:0] src2 = 64'd0;
   logic [4:0]  ctrl_alu = 5'd0;
   logic        in_ready;
   logic        out_valid;
   logic [63:0] sll_out;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   ysyx_22041461_sll_iter #(.STEP(STEP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .src1      (src1),
      .src2      (src2),
      .ctrl_ALU  (ctrl_alu),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .SLL_out   (sll_out)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic int ref_shamt(input logic [63:0] b, input logic [4:0] c);
      if (c == ALU_SLL) return int'(b[5:0]);
      if (c == ALU_SLLW || c == ALU_SLLIW) return int'(b[4:0]);
      return 0;
   endfunction

   function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b, input logic [4:0] c);
      logic [31:0] w;
      if (c == ALU_SLL) return a << ref_shamt(b, c);
      if (c == ALU_SLLW || c == ALU_SLLIW) begin
         w = a[31:0] << ref_shamt(b, c);
         return {{32{w[31]}}, w};
      end
      return 64'd0;
   endfunction

   function automatic int ref_latency(input logic [63:0] a, input logic [63:0] b, input logic [4:0] c);
      int sh;
      int n;
      sh = ref_shamt(b, c);
      n  = (sh + STEP - 1) / STEP;
      if (n < 1) n = 1;
`ifdef YSYX_22041461_SLL_EARLY_OUT_EN
      for (int j = 0; j < n; j++) begin
         logic [63:0] v;
         v = a << ((j * STEP < sh) ? j * STEP : sh);
         if (c == ALU_SLLW || c == ALU_SLLIW) v = {32'd0, v[31:0]};
         if (v == 64'd0) return j + 1;
      end
`endif
      return n;
   endfunction

   // Monitor: compares every accepted result with the oldest expectation.
   always @(negedge clk) begin
      #1;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%h expected=none", sll_out);
         end else begin
            check("result", sll_out, exp_q.pop_front());
         end
      end
   end

   task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [4:0] c, input int hold);
      int lat;
      logic [63:0] held;
      @(negedge clk);
      check("in_ready_idle", 64'(in_ready), 64'd1);
      src1 = a; src2 = b; ctrl_alu = c; in_valid = 1'b1; out_ready = 1'b0;
      exp_q.push_back(ref_result(a, b, c));
      @(negedge clk);
      in_valid = 1'b0;
      check("in_ready_busy", 64'(in_ready), 64'd0);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'(ref_latency(a, b, c)));
      held = sll_out;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_data", sll_out, held);
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_after_take", 64'(in_ready), 64'd1);
      check("valid_after_take", 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [4:0]  c;
      logic [63:0] a;
      logic        seen;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_sll_out", sll_out, 64'd0);
      rst_n = 1'b1;

      issue(64'h1, 64'd63, ALU_SLL, 0);
      issue(64'hFFFF_FFFF_0000_0001, 64'h3F, ALU_SLLW, 0);
      issue(64'h0800_0000, 64'd4, ALU_SLLIW, 0);
      issue(64'hDEAD_BEEF_1234_5678, 64'd0, ALU_SLL, 0);
      issue(64'hDEAD_BEEF_1234_5678, 64'd7, 5'b00000, 0);
      issue(64'hA5, 64'd8, ALU_SLL, 0);
      issue(64'hA5, 64'd9, ALU_SLL, 0);
      issue(64'd0, 64'd63, ALU_SLL, 0);
      issue(64'h1234, 64'd5, ALU_SLL, 5);

      // flush during the third SHIFT cycle of a shamt-40 op
      @(negedge clk);
      src1 = 64'h1; src2 = 64'd40; ctrl_alu = ALU_SLL; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_in_ready", 64'(in_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      check("flush_no_valid", 64'(seen), 64'd0);
      issue(64'h1, 64'd1, ALU_SLL, 0);

      // flush in IDLE drops a same-cycle request
      @(negedge clk);
      src1 = 64'h3; src2 = 64'd2; ctrl_alu = ALU_SLL; in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      check("flush_idle_in_ready", 64'(in_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      check("flush_idle_no_valid", 64'(seen), 64'd0);

      // async reset mid-SHIFT, checked before any clock edge
      @(negedge clk);
      src1 = 64'hF; src2 = 64'd63; ctrl_alu = ALU_SLL; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_in_ready", 64'(in_ready), 64'd1);
      check("async_rst_out_valid", 64'(out_valid), 64'd0);
      check("async_rst_sll_out", sll_out, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 3))
            0: c = ALU_SLL;
            1: c = ALU_SLLW;
            2: c = ALU_SLLIW;
            default: c = 5'($urandom_range(0, 31));
         endcase
         a = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) a = 64'd0;
         issue(a, {$urandom, $urandom}, c, $urandom_range(0, 3));
      end

      repeat (2) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
